wb2reg_bridge: RTL and testbench

Wishbone classic slave that acts as the initiator on the peripheral register bus (reg_cs/reg_wr/reg_addr/reg_wdata/reg_be → reg_rdata/reg_ack) used by the UART, I2C and SPI register blocks.
- Converts one WB single access into one reg-bus access.
- Holds the reg-bus address stable for the whole access, because responders register their block select on reg_cs.
- Sits between the WB interconnect slave port and the peripheral wrapper, in the app_clk domain.

---
 rtl/wb2reg_pkg.sv | 14 +
 rtl/wb2reg_bridge_if.sv | 37 +++
 rtl/wb2reg_timer.sv | 30 +++
 rtl/wb2reg_bridge.sv | 117 +++++++++++
 tb/tb_wb2reg_bridge.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/wb2reg_pkg.sv
// rtl/wb2reg_pkg.sv - shared types and constants for the wb2reg bridge
package wb2reg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int          TO_CYCLES_DEF = 255;
  localparam logic [31:0] ERR_RDATA     = 32'h0;

endpackage

// File: rtl/wb2reg_bridge_if.sv
// rtl/wb2reg_bridge_if.sv - Wishbone slave side plus reg-bus initiator side of the bridge
interface wb2reg_bridge_if #(parameter int AW = 11);

  logic          wbs_cyc_i;
  logic          wbs_stb_i;
  logic [31:0]   wbs_adr_i;
  logic          wbs_we_i;
  logic [31:0]   wbs_dat_i;
  logic [3:0]    wbs_sel_i;
  logic [31:0]   wbs_dat_o;
  logic          wbs_ack_o;
  logic          wbs_err_o;

  logic          reg_cs;
  logic          reg_wr;
  logic [AW-1:0] reg_addr;
  logic [31:0]   reg_wdata;
  logic [3:0]    reg_be;
  logic [31:0]   reg_rdata;
  logic          reg_ack;

  // slave: the bridge view; master: the WB master plus reg-bus responder environment
  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_adr_i, wbs_we_i, wbs_dat_i, wbs_sel_i,
    input  reg_rdata, reg_ack,
    output wbs_dat_o, wbs_ack_o, wbs_err_o,
    output reg_cs, reg_wr, reg_addr, reg_wdata, reg_be
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_adr_i, wbs_we_i, wbs_dat_i, wbs_sel_i,
    output reg_rdata, reg_ack,
    input  wbs_dat_o, wbs_ack_o, wbs_err_o,
    input  reg_cs, reg_wr, reg_addr, reg_wdata, reg_be
  );

endinterface

// File: rtl/wb2reg_timer.sv
// rtl/wb2reg_timer.sv - reg_ack timeout down-counter (used only with WB2REG_TIMEOUT_EN)
module wb2reg_timer #(
  parameter int TO_CYCLES = 255
) (
  input  logic app_clk,
  input  logic srst,
  input  logic load,
  input  logic tick,
  output logic expired
);

  localparam int CW = ($clog2(TO_CYCLES + 1) > 8) ? $clog2(TO_CYCLES + 1) : 8;

  logic [CW-1:0] cnt;

  always_ff @(posedge app_clk) begin
    if (srst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(TO_CYCLES);
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Fires on the waiting cycle whose decrement would reach zero, so a full
  // TO_CYCLES cycles of waiting are granted before the access is given up.
  assign expired = tick && (cnt <= CW'(1));

endmodule

// File: rtl/wb2reg_bridge.sv
// rtl/wb2reg_bridge.sv - Wishbone classic slave to peripheral reg-bus initiator
// Optional reg_ack timeout enabled by defining WB2REG_TIMEOUT_EN.
module wb2reg_bridge
  import wb2reg_pkg::*;
#(
  parameter int AW        = 11,
  parameter int TO_CYCLES = TO_CYCLES_DEF
) (
  input  logic            app_clk,
  input  logic            srst,
  wb2reg_bridge_if.slave  bus
);

  state_t        state;
  logic          cs_q;
  logic          wr_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    be_q;
  logic [31:0]   dat_q;
  logic          ack_q;
  logic          err_q;
  logic          wb_req;
  logic          expired;
  logic          unused_adr_hi;

  assign wb_req        = bus.wbs_cyc_i && bus.wbs_stb_i;
  assign unused_adr_hi = ^bus.wbs_adr_i[31:AW];

`ifdef WB2REG_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
  logic tmr_load;
  logic tmr_tick;

  // Reload on entry to REQ and on the REQ->DRAIN abort transition.
  assign tmr_load = ((state == IDLE) && wb_req) ||
                    ((state == REQ) && !bus.reg_ack && !bus.wbs_cyc_i);
  assign tmr_tick = ((state == REQ) || (state == DRAIN)) && !bus.reg_ack;

  wb2reg_timer #(.TO_CYCLES(TO_CYCLES)) u_timer (
    .app_clk (app_clk),
    .srst    (srst),
    .load    (tmr_load),
    .tick    (tmr_tick),
    .expired (expired)
  );
`else
  localparam bit TIMEOUT_EN = 1'b0;
  assign expired = 1'b0;
`endif

  always_ff @(posedge app_clk) begin
    if (srst) begin
      state   <= IDLE;
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      dat_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wb_req) begin
            addr_q  <= bus.wbs_adr_i[AW-1:0];
            wr_q    <= bus.wbs_we_i;
            wdata_q <= bus.wbs_dat_i;
            be_q    <= bus.wbs_sel_i;
            cs_q    <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          // reg_ack has priority over both abort and timeout
          if (bus.reg_ack) begin
            cs_q  <= 1'b0;
            dat_q <= wr_q ? ERR_RDATA : bus.reg_rdata;
            ack_q <= 1'b1;
            state <= RESP;
          end else if (!bus.wbs_cyc_i) begin
            state <= DRAIN;
          end else if (expired) begin
            cs_q  <= 1'b0;
            dat_q <= ERR_RDATA;
            err_q <= 1'b1;
            state <= RESP;
          end
        end
        RESP: begin
          ack_q <= 1'b0;
          err_q <= 1'b0;
          state <= IDLE;
        end
        DRAIN: begin
          // an issued reg-bus access cannot be cancelled; wait it out silently
          if (bus.reg_ack || expired) begin
            cs_q  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.reg_cs    = cs_q;
  assign bus.reg_wr    = wr_q;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_be    = be_q;
  assign bus.wbs_dat_o = dat_q;
  assign bus.wbs_ack_o = ack_q;
  assign bus.wbs_err_o = TIMEOUT_EN && err_q;

endmodule

// File: tb/tb_wb2reg_bridge.sv
// tb/tb_wb2reg_bridge.sv - self-checking bench for wb2reg_bridge
module tb_wb2reg_bridge;

  localparam int AW = 11;

  logic app_clk;
  logic srst;
  int   checks;
  int   errors;

  wb2reg_bridge_if #(.AW(AW)) bus ();

  wb2reg_bridge #(.AW(AW), .TO_CYCLES(8)) dut (
    .app_clk (app_clk),
    .srst    (srst),
    .bus     (bus.slave)
  );

  initial app_clk = 1'b0;
  always #5 app_clk = ~app_clk;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          dly;
    logic [31:0] rdata;
    logic        hold;
    logic [31:0] exp_addr;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge app_clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " reg_cs"},    32'(bus.reg_cs),    32'h0);
    chk({tag, " reg_wr"},    32'(bus.reg_wr),    32'h0);
    chk({tag, " reg_addr"},  32'(bus.reg_addr),  32'h0);
    chk({tag, " reg_wdata"}, bus.reg_wdata,      32'h0);
    chk({tag, " reg_be"},    32'(bus.reg_be),    32'h0);
    chk({tag, " dat_o"},     bus.wbs_dat_o,      32'h0);
    chk({tag, " ack_o"},     32'(bus.wbs_ack_o), 32'h0);
    chk({tag, " err_o"},     32'(bus.wbs_err_o), 32'h0);
  endtask

  task automatic start_req(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = dat;
    bus.wbs_sel_i = sel;
  endtask

  task automatic drop_req();
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    start_req(v.we, v.adr, v.dat, v.sel);
    tick();
    chk({t, " cs_rise"}, 32'(bus.reg_cs),   32'h1);
    chk({t, " addr"},    32'(bus.reg_addr), v.exp_addr);
    chk({t, " wr"},      32'(bus.reg_wr),   32'(v.we));
    chk({t, " be"},      32'(bus.reg_be),   32'(v.sel));
    if (v.we) chk({t, " wdata"}, bus.reg_wdata, v.dat);
    for (int d = 0; d < v.dly; d++) begin
      tick();
      chk({t, " cs_hold"},   32'(bus.reg_cs),    32'h1);
      chk({t, " addr_hold"}, 32'(bus.reg_addr),  v.exp_addr);
      chk({t, " be_hold"},   32'(bus.reg_be),    32'(v.sel));
      chk({t, " no_ack"},    32'(bus.wbs_ack_o), 32'h0);
    end
    bus.reg_ack   = 1'b1;
    bus.reg_rdata = v.rdata;
    tick();
    bus.reg_ack   = 1'b0;
    chk({t, " ack"},      32'(bus.wbs_ack_o), 32'h1);
    chk({t, " err"},      32'(bus.wbs_err_o), 32'h0);
    chk({t, " dat_o"},    bus.wbs_dat_o,      v.exp_dat);
    chk({t, " cs_fall"},  32'(bus.reg_cs),    32'h0);
    if (!v.hold) drop_req();
    tick();
    chk({t, " ack_once"}, 32'(bus.wbs_ack_o), 32'h0);
    chk({t, " cs_gap"},   32'(bus.reg_cs),    32'h0);
    chk({t, " dat_keep"}, bus.wbs_dat_o,      v.exp_dat);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    srst   = 1'b1;
    drop_req();
    bus.wbs_we_i  = 1'b0;
    bus.wbs_adr_i = '0;
    bus.wbs_dat_i = '0;
    bus.wbs_sel_i = '0;
    bus.reg_ack   = 1'b0;
    bus.reg_rdata = '0;

    //        we    adr            dat            sel   dly rdata          hold  exp_addr  exp_dat
    vecs[0] = '{1'b1, 32'h0000_0044, 32'h0000_00A5, 4'h1, 2, 32'h0000_DEAD, 1'b0, 32'h044, 32'h0};
    vecs[1] = '{1'b0, 32'h0000_0088, 32'h0,         4'hF, 0, 32'h0000_003C, 1'b0, 32'h088, 32'h0000_003C};
    vecs[2] = '{1'b0, 32'h0000_0100, 32'h0,         4'hF, 1, 32'h1111_2222, 1'b1, 32'h100, 32'h1111_2222};
    vecs[3] = '{1'b1, 32'hFFFF_F7FC, 32'h1234_5678, 4'hC, 0, 32'h0000_0BAD, 1'b1, 32'h7FC, 32'h0};
    vecs[4] = '{1'b0, 32'h0000_0004, 32'h0,         4'h3, 3, 32'hCAFE_F00D, 1'b1, 32'h004, 32'hCAFE_F00D};
    vecs[5] = '{1'b0, 32'h0000_07FF, 32'h0,         4'h8, 0, 32'hA5A5_A5A5, 1'b0, 32'h7FF, 32'hA5A5_A5A5};

    tick();
    tick();
    chk_all_zero("reset");
    srst = 1'b0;
    tick();

    // stray reg_ack while idle must be ignored
    bus.reg_ack   = 1'b1;
    bus.reg_rdata = 32'hFFFF_FFFF;
    tick();
    bus.reg_ack   = 1'b0;
    tick();
    chk("idle_ack cs",  32'(bus.reg_cs),    32'h0);
    chk("idle_ack ack", 32'(bus.wbs_ack_o), 32'h0);
    chk("idle_ack dat", bus.wbs_dat_o,      32'h0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // abort: cyc drops one cycle into REQ, reg_ack arrives three cycles later
    start_req(1'b0, 32'h0000_0020, 32'h0, 4'hF);
    tick();
    chk("abort cs_rise", 32'(bus.reg_cs), 32'h1);
    drop_req();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("abort cs_hold", 32'(bus.reg_cs),    32'h1);
      chk("abort no_ack",  32'(bus.wbs_ack_o), 32'h0);
    end
    bus.reg_ack   = 1'b1;
    bus.reg_rdata = 32'h5555_5555;
    tick();
    bus.reg_ack   = 1'b0;
    chk("abort cs_fall", 32'(bus.reg_cs),    32'h0);
    chk("abort no_ack2", 32'(bus.wbs_ack_o), 32'h0);
    chk("abort no_err",  32'(bus.wbs_err_o), 32'h0);
    chk("abort dat",     bus.wbs_dat_o,      32'hA5A5_A5A5);
    tick();
    chk("abort quiet",   32'(bus.wbs_ack_o), 32'h0);

    // reset in the middle of an access
    start_req(1'b1, 32'h0000_0010, 32'hFEED_BEEF, 4'hF);
    tick();
    chk("rst_mid cs", 32'(bus.reg_cs), 32'h1);
    srst = 1'b1;
    drop_req();
    tick();
    chk_all_zero("rst_mid");
    srst = 1'b0;
    tick();
    chk("rst_mid idle", 32'(bus.wbs_ack_o), 32'h0);
    run_vec('{1'b0, 32'h0000_0030, 32'h0, 4'hF, 1, 32'h0BAD_CAFE, 1'b0, 32'h030, 32'h0BAD_CAFE}, 9);

    // reg_ack never arrives
    start_req(1'b0, 32'h0000_0040, 32'h0, 4'hF);
    tick();
`ifdef WB2REG_TIMEOUT_EN
    for (int k = 0; k < 7; k++) begin
      tick();
      chk("to cs_hold", 32'(bus.reg_cs),    32'h1);
      chk("to no_err",  32'(bus.wbs_err_o), 32'h0);
    end
    tick();
    chk("to err",    32'(bus.wbs_err_o), 32'h1);
    chk("to no_ack", 32'(bus.wbs_ack_o), 32'h0);
    chk("to dat",    bus.wbs_dat_o,      32'h0);
    chk("to cs",     32'(bus.reg_cs),    32'h0);
    drop_req();
    tick();
    chk("to err_once", 32'(bus.wbs_err_o), 32'h0);
`else
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("wait cs_hold", 32'(bus.reg_cs),    32'h1);
      chk("wait no_ack",  32'(bus.wbs_ack_o), 32'h0);
      chk("wait no_err",  32'(bus.wbs_err_o), 32'h0);
    end
    bus.reg_ack   = 1'b1;
    bus.reg_rdata = 32'h0000_7777;
    tick();
    bus.reg_ack   = 1'b0;
    chk("wait late_ack", 32'(bus.wbs_ack_o), 32'h1);
    chk("wait late_dat", bus.wbs_dat_o,      32'h0000_7777);
    drop_req();
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
